// File: rtl/acceptance_filter.sv
// CAN standard-ID acceptance filter: deserialises the identifier MSB first, then compares it to code/mask.
// Optional ACCEPT_COUNT_EN adds an 8-bit saturating count of accepted frames (accept_cnt).
module acceptance_filter #(
  parameter int ID_W = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ID_W-1:0] mask_param,
  input  logic [ID_W-1:0] code_param,
  input  logic            sof,
  input  logic            id_bit,
  input  logic            id_bit_vld,
  input  logic            abort,
  output logic [ID_W-1:0] rx_id,
  output logic            id_done,
  output logic            accept,
  output logic            busy
`ifdef ACCEPT_COUNT_EN
  ,
  output logic [7:0]      accept_cnt
`endif
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, EVAL} state_t;

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_shift, w_shift_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ID_W-1:0]  r_rx_id, w_rx_id_nxt;
  logic             r_accept, w_accept_nxt;
  logic             r_id_done, w_id_done_nxt;
  logic             w_match;
  logic             w_last;

  assign w_match = ((r_shift ^ code_param) & mask_param) == '0;
  assign w_last  = (r_cnt == CNT_W'(ID_W - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_rx_id_nxt   = r_rx_id;
    w_accept_nxt  = r_accept;
    w_id_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (!abort && sof) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
          if (id_bit_vld) begin
            w_shift_nxt = {r_shift[ID_W-2:0], id_bit};
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (sof) begin
          // A new SOF discards the partial identifier; a coincident bit is the new MSB.
          w_cnt_nxt = '0;
          if (id_bit_vld) begin
            w_shift_nxt = {r_shift[ID_W-2:0], id_bit};
            w_cnt_nxt   = CNT_W'(1);
          end
        end else if (id_bit_vld) begin
          w_shift_nxt = {r_shift[ID_W-2:0], id_bit};
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (w_last) begin
            w_state_nxt = EVAL;
          end
        end
      end
      EVAL: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_rx_id_nxt   = r_shift;
          w_accept_nxt  = w_match;
          w_id_done_nxt = 1'b1;
          w_state_nxt   = IDLE;
          if (sof) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = '0;
            if (id_bit_vld) begin
              w_shift_nxt = {r_shift[ID_W-2:0], id_bit};
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_rx_id   <= '0;
      r_accept  <= 1'b0;
      r_id_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rx_id   <= w_rx_id_nxt;
      r_accept  <= w_accept_nxt;
      r_id_done <= w_id_done_nxt;
    end
  end

  assign rx_id   = r_rx_id;
  assign accept  = r_accept;
  assign id_done = r_id_done;
  assign busy    = (r_state != IDLE);

`ifdef ACCEPT_COUNT_EN
  logic [7:0] r_accept_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_accept_cnt <= 8'd0;
    end else if (r_id_done && r_accept && (r_accept_cnt != 8'hFF)) begin
      r_accept_cnt <= r_accept_cnt + 8'd1;
    end
  end

  assign accept_cnt = r_accept_cnt;
`endif

endmodule
